// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-port arbiter/sequencer sharing one 256x8 data-memory port.
//            Optional macro DM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module dm_arbiter #(
    parameter int             AW       = 8,
    parameter int             DW       = 8,
    parameter logic [AW-1:0]  P1_WR_LO = 8'h80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic [AW-1:0] mem_ea,
    output logic [DW-1:0] mem_result,
    output logic          mem_en,
    input  logic [DW-1:0] mem_data
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t          state_q,  state_d;
    logic            last_q,   last_d;
    logic            sel_q,    sel_d;
    logic            we_q,     we_d;
    logic            blk_q,    blk_d;
    logic [AW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]   wdata_q,  wdata_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic            err1_q,   err1_d;
    logic            w_win1;
    logic            w_we;
    logic [AW-1:0]   w_addr;

    always_comb begin
`ifdef DM_ARB_FIXED_PRIO_EN
        w_win1 = req1 & ~req0;
`else
        // On contention the port that did not win last time is served.
        w_win1 = req1 & (~req0 | ~last_q);
`endif
        w_we   = w_win1 ? we1   : we0;
        w_addr = w_win1 ? addr1 : addr0;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        we_d      = we_q;
        blk_d     = blk_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err1_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d = ST_ACCESS;
                    sel_d   = w_win1;
                    we_d    = w_we;
                    addr_d  = w_addr;
                    wdata_d = w_win1 ? wdata1 : wdata0;
                    blk_d   = w_win1 & w_we & (w_addr < P1_WR_LO);
                    if (req0 & req1) begin
                        last_d = w_win1;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (sel_q) begin
                    rvalid1_d = 1'b1;
                    err1_d    = blk_q;
                    if (!we_q) begin
                        rdata1_d = mem_data;
                    end
                end else begin
                    rvalid0_d = 1'b1;
                    if (!we_q) begin
                        rdata0_d = mem_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            blk_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            blk_q     <= blk_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err1_q    <= err1_d;
        end
    end

    // The memory writes at the mid-cycle negedge, so reset must veto the
    // enable combinationally to stop a write in the cycle it is asserted.
    assign mem_en     = (state_q == ST_ACCESS) & we_q & ~blk_q & ~rst;
    assign gnt0       = (state_q == ST_ACCESS) & ~sel_q;
    assign gnt1       = (state_q == ST_ACCESS) &  sel_q;
    assign mem_ea     = addr_q;
    assign mem_result = wdata_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign err1       = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Scoreboard bench for dm_arbiter with a behavioural memory model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_arbiter;

    localparam logic [7:0] P1_WR_LO = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, err1, mem_en;
    logic [7:0] rdata0, rdata1, mem_ea, mem_result;
    wire  [7:0] mem_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(8), .DW(8), .P1_WR_LO(P1_WR_LO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err1(err1),
        .mem_ea(mem_ea), .mem_result(mem_result), .mem_en(mem_en),
        .mem_data(mem_data)
    );

    // Memory the DUT drives: write at negedge, combinational read.
    logic [7:0] mem [256];
    always @(negedge clk) if (mem_en) mem[mem_ea] <= mem_result;
    assign mem_data = mem[mem_ea];

    // Reference model: request-level arbitration and an independent memory image.
    typedef struct { logic [7:0] rd; bit err; } resp_t;
    resp_t      q0[$], q1[$];
    logic [7:0] ref_mem [256];
    bit         m_busy, m_sel, m_last, m_we, m_blk;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_rdata [2];

    always @(posedge clk) begin
        bit pick1;
        if (rst) begin
            m_busy = 0; m_last = 1; m_sel = 0; m_we = 0; m_blk = 0;
            m_addr = 0; m_wdata = 0; m_rdata[0] = 0; m_rdata[1] = 0;
            q0.delete(); q1.delete();
        end else if (m_busy) begin
            m_busy = 0;
            if (!m_we)      m_rdata[m_sel] = ref_mem[m_addr];
            else if (!m_blk) ref_mem[m_addr] = m_wdata;
            if (m_sel) q1.push_back('{m_rdata[1], m_blk});
            else       q0.push_back('{m_rdata[0], 1'b0});
        end else if (req0 || req1) begin
            if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
                pick1 = 0;
`else
                pick1 = !m_last;
`endif
                m_last = pick1;
            end else begin
                pick1 = req1;
            end
            m_sel   = pick1;
            m_we    = pick1 ? we1 : we0;
            m_addr  = pick1 ? addr1 : addr0;
            m_wdata = pick1 ? wdata1 : wdata0;
            m_blk   = pick1 && m_we && (m_addr < P1_WR_LO);
            m_busy  = 1;
        end
    end

    // Monitor: per-cycle interface check plus scoreboard pop on each rvalid.
    always @(negedge clk) begin
        logic exp_g0, exp_g1, exp_en;
        resp_t r;
        exp_g0 = m_busy && !m_sel;
        exp_g1 = m_busy && m_sel;
        exp_en = m_busy && m_we && !m_blk && !rst;
        tests++;
        if ({gnt0, gnt1, mem_en, mem_ea, mem_result, rdata0, rdata1} !==
            {exp_g0, exp_g1, exp_en, m_addr, m_wdata, m_rdata[0], m_rdata[1]}) begin
            fails++;
            $display("FAIL cycle@%0t gnt0/gnt1/en/ea/result/rdata0/rdata1 got %b %b %b %h %h %h %h need %b %b %b %h %h %h %h",
                     $time, gnt0, gnt1, mem_en, mem_ea, mem_result, rdata0, rdata1,
                     exp_g0, exp_g1, exp_en, m_addr, m_wdata, m_rdata[0], m_rdata[1]);
        end
        if (rvalid0 || q0.size() != 0) begin
            tests++;
            if (!rvalid0 || q0.size() == 0) begin
                fails++;
                $display("FAIL rvalid0@%0t got %b need %b", $time, rvalid0, q0.size() != 0);
                q0.delete();
            end else begin
                r = q0.pop_front();
                if (rdata0 !== r.rd) begin
                    fails++;
                    $display("FAIL rdata0@%0t got %h need %h", $time, rdata0, r.rd);
                end
            end
        end
        if (rvalid1 || q1.size() != 0 || err1) begin
            tests++;
            if (!rvalid1 || q1.size() == 0) begin
                fails++;
                $display("FAIL rvalid1@%0t got %b err1 %b need %b", $time, rvalid1, err1, q1.size() != 0);
                q1.delete();
            end else begin
                r = q1.pop_front();
                if (rdata1 !== r.rd || err1 !== r.err) begin
                    fails++;
                    $display("FAIL resp1@%0t rdata1/err1 got %h %b need %h %b",
                             $time, rdata1, err1, r.rd, r.err);
                end
            end
        end
    end

    // One requester transaction: hold req until gnt seen, drop at the edge ending it.
    task automatic txn(input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
        bit g = 0;
        int n = 0;
        if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        do begin
            @(negedge clk);
            g = (p == 0) ? gnt0 : gnt1;
            @(posedge clk); #1;
            n++;
        end while (!g && n < 300);
        if (!g) begin
            tests++; fails++;
            $display("FAIL gnt%0d timeout got 0 need 1", p);
        end
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] pool [6];
        pool = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h10, 8'h81};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic rand_port(input int p, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            txn(p, bit'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        tests++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err1, mem_en, rdata0, rdata1, mem_ea, mem_result} !== 38'd0) begin
            fails++;
            $display("FAIL reset_values got %b need 0",
                     {gnt0, gnt1, rvalid0, rvalid1, err1, mem_en, rdata0, rdata1, mem_ea, mem_result});
        end
        @(posedge clk); #1;

        txn(0, 1, 8'h10, 8'hA5);
        txn(0, 0, 8'h10, 8'h00);

        fork
            repeat (4) txn(0, 0, 8'h90, 8'h00);
            repeat (4) txn(1, 0, 8'h91, 8'h00);
        join

        txn(1, 1, 8'h20, 8'h3C);
        txn(0, 0, 8'h20, 8'h00);
        txn(1, 1, 8'h80, 8'h77);
        txn(1, 0, 8'h80, 8'h00);

        // Reset asserted in the middle of a port 0 write ACCESS.
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'hEE;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0; req0 = 0;
        txn(0, 0, 8'h05, 8'h00);

        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join

        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain pending responses got %0d/%0d need 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
